cache_port_arbiter: RTL and testbench
=====================================

# cache_port_arbiter

Two-requester arbiter that shares the single-port cache subsystem (cache, controller, backing data memory) between port A (instruction fetch) and port B (load/store). Round-robin arbitration latches each granted request, holds it on the cache's CPU-side port until the cache stops stalling, and returns read data and a completion pulse to the owning port. It sits between the two pipeline requesters and the cache top level; the cache is otherwise unchanged.

## Interface
- ADDR_WIDTH, 10, word address width; equals the cache address width.
- DATA_WIDTH, 32, CPU data width.
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- ReadA, WriteA  in  1 each  port A request. Both high is treated as a write.
- AddressA  in  ADDR_WIDTH  port A address.
- DataInA  in  DATA_WIDTH  port A write data.
- StallA  out  1  port A stall: (ReadA|WriteA) & ~DoneA, combinational.
- DoneA  out  1  one-cycle pulse, registered, marking completion of port A's access.
- DataOutA  out  DATA_WIDTH  port A read data, registered, held between reads.
- ReadB, WriteB, AddressB, DataInB, StallB, DoneB, DataOutB  same definitions for port B.
- MemReadCpu, MemWriteCpu  out  1 each  read/write request to the cache.
- Address  out  ADDR_WIDTH  latched address to the cache.
- DataIn  out  DATA_WIDTH  latched write data to the cache.
- Stall  in  1  cache stall; high while a miss or refill is in progress.
- DataOut  in  DATA_WIDTH  cache read data, valid in the cycle Stall is low.

## Operation
- States: IDLE, GRANT_A, GRANT_B, DONE_A, DONE_B.
- IDLE:
  - One port requesting: grant that port.
  - Both requesting: grant the port that is not LastServed.
  - On grant, latch op (write if Write, else read), address and write data into the request registers, and load LastServed.
  - No request: stay in IDLE.
- GRANT_x:
  - Drive MemReadCpu or MemWriteCpu from the latched op. Address and DataIn come from the latched registers.
  - At each edge where Stall=0, the access completes. For a read, capture DataOut into DataOut_x. Go to DONE_x.
  - While Stall=1, stay in GRANT_x indefinitely (a miss refill takes several cycles). There is no timeout.
- DONE_x:
  - Done_x=1 for exactly this cycle. Downstream requests are 0.
  - Port x's request is ignored this cycle, because it is still asserted for the access just served.
  - If the other port is requesting, grant it directly (latch its request as in IDLE). Otherwise go to IDLE.
- A request withdrawn or changed during GRANT_x does not alter the latched access. It still completes and Done_x still pulses.
- A requester must hold its signals stable until it sees Done. A read's data is valid in DataOut_x from the Done cycle onward.
- Downstream Stall and DataOut are ignored outside GRANT states.
- Reset (RST low, asynchronous):
  - State goes to IDLE; LastServed goes to B, so A wins the first tie.
  - MemReadCpu, MemWriteCpu, DoneA and DoneB go to 0 immediately.
  - Address, DataIn, DataOutA and DataOutB go to 0.
  - An in-flight access is abandoned. The cache shares this reset.
  - After release, operation resumes from IDLE on the next edge.

## Timing
- Grant latency: a request seen in IDLE at edge n appears downstream in cycle n+1.
- Hit (Stall=0 in the first GRANT cycle): Done in cycle n+2.
- Miss with Stall high for k cycles: Done in cycle n+2+k.
- Back-to-back alternating ports: one access per 2 cycles (GRANT, DONE).
- Same port back-to-back: one access per 3 cycles (GRANT, DONE, IDLE).
- StallA/StallB are combinational from the port request and the registered Done. Low in the Done cycle only.
- At most one of DoneA/DoneB is high in any cycle. MemReadCpu and MemWriteCpu are never both high.

## Test plan
- Reset, then ReadA=1 @0x005 with the cache hitting and returning 0xDEADBEEF: MemReadCpu=1, Address=0x005 in cycle 1; DoneA=1, DataOutA=0xDEADBEEF in cycle 2; StallA low only in cycle 2.
- WriteB @0x3F0, data 0x12345678, Stall held high 5 cycles: MemWriteCpu high for 6 cycles with Address/DataIn stable; DoneB pulses once afterwards; DoneA stays 0.
- ReadA and ReadB asserted together and held continuously from reset: grants alternate A, B, A, B; each Done is 2 cycles apart; no port is granted twice in a row.
- ReadA and WriteA both high @0x010: served as a write (MemWriteCpu=1, MemReadCpu=0); DataOutA unchanged.
- Drop ReadA one cycle after grant while Stall=1: access still completes; DoneA pulses; no second grant to A.
- Assert RST low mid-GRANT_B with Stall=1: MemWriteCpu, MemReadCpu and DoneB go to 0 without a clock edge; after release with ReadA and ReadB pending, A is granted first.

Source files
------------

// File: rtl/cache_port_arbiter_if.sv
// Bundle of both requester ports plus the cache CPU-side port.
// slave: arbiter view; master: requesters and cache around it.
interface cache_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  ReadA, WriteA;
  logic [ADDR_WIDTH-1:0] AddressA;
  logic [DATA_WIDTH-1:0] DataInA;
  logic                  StallA, DoneA;
  logic [DATA_WIDTH-1:0] DataOutA;

  logic                  ReadB, WriteB;
  logic [ADDR_WIDTH-1:0] AddressB;
  logic [DATA_WIDTH-1:0] DataInB;
  logic                  StallB, DoneB;
  logic [DATA_WIDTH-1:0] DataOutB;

  logic                  MemReadCpu, MemWriteCpu;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] DataIn;
  logic                  Stall;
  logic [DATA_WIDTH-1:0] DataOut;

  modport slave (
    input  ReadA, WriteA, AddressA, DataInA,
    output StallA, DoneA, DataOutA,
    input  ReadB, WriteB, AddressB, DataInB,
    output StallB, DoneB, DataOutB,
    output MemReadCpu, MemWriteCpu, Address, DataIn,
    input  Stall, DataOut
  );

  modport master (
    output ReadA, WriteA, AddressA, DataInA,
    input  StallA, DoneA, DataOutA,
    output ReadB, WriteB, AddressB, DataInB,
    input  StallB, DoneB, DataOutB,
    input  MemReadCpu, MemWriteCpu, Address, DataIn,
    output Stall, DataOut
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache CPU port between fetch (A) and load/store (B).
// Each grant is latched and held on the cache port until Stall drops.
module cache_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic                 CLK,
  input logic                 RST,
  cache_port_arbiter_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT_A = 3'd1;
  localparam logic [2:0] S_GRANT_B = 3'd2;
  localparam logic [2:0] S_DONE_A  = 3'd3;
  localparam logic [2:0] S_DONE_B  = 3'd4;

  logic [2:0] state, state_nx;
  logic       last_b, op_wr, gnt_vld, gnt_sel, granting;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;

  // per-port views, index 0 = A, 1 = B
  logic [1:0]                 req, wr, done;
  logic [1:0][ADDR_WIDTH-1:0] port_addr;
  logic [1:0][DATA_WIDTH-1:0] port_din, dout_q;

  assign req       = {bus.ReadB | bus.WriteB, bus.ReadA | bus.WriteA};
  assign wr        = {bus.WriteB, bus.WriteA};
  assign port_addr = {bus.AddressB, bus.AddressA};
  assign port_din  = {bus.DataInB, bus.DataInA};

  // DONE_x skips port x: its request is still up for the access just served
  always_comb begin
    state_nx = state;
    gnt_vld  = 1'b0;
    gnt_sel  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req[0] && (!req[1] || last_b)) begin
          gnt_vld = 1'b1;
          gnt_sel = 1'b0;
        end else if (req[1]) begin
          gnt_vld = 1'b1;
          gnt_sel = 1'b1;
        end
      end
      S_GRANT_A: if (!bus.Stall) state_nx = S_DONE_A;
      S_GRANT_B: if (!bus.Stall) state_nx = S_DONE_B;
      S_DONE_A: begin
        if (req[1]) begin
          gnt_vld = 1'b1;
          gnt_sel = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_DONE_B: begin
        if (req[0]) begin
          gnt_vld = 1'b1;
          gnt_sel = 1'b0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (gnt_vld) state_nx = gnt_sel ? S_GRANT_B : S_GRANT_A;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      last_b <= 1'b1;
      op_wr  <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      state <= state_nx;
      if (gnt_vld) begin
        last_b <= gnt_sel;
        op_wr  <= wr[gnt_sel];
        addr_q <= port_addr[gnt_sel];
        din_q  <= port_din[gnt_sel];
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam logic [2:0] GST = (p == 0) ? S_GRANT_A : S_GRANT_B;
    logic [DATA_WIDTH-1:0] dq;
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                                    dq <= '0;
      else if (state == GST && !bus.Stall && !op_wr) dq <= bus.DataOut;
    end
    assign dout_q[p] = dq;
  end

  assign granting = (state == S_GRANT_A) || (state == S_GRANT_B);
  assign done     = {state == S_DONE_B, state == S_DONE_A};

  assign bus.MemReadCpu  = granting & ~op_wr;
  assign bus.MemWriteCpu = granting & op_wr;
  assign bus.Address     = addr_q;
  assign bus.DataIn      = din_q;

  assign bus.DoneA    = done[0];
  assign bus.DoneB    = done[1];
  assign bus.StallA   = req[0] & ~done[0];
  assign bus.StallB   = req[1] & ~done[1];
  assign bus.DataOutA = dout_q[0];
  assign bus.DataOutB = dout_q[1];
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: vector table of single accesses plus
// sequences for round-robin, withdrawn request and mid-access reset.
module tb_cache_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  cache_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  cache_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic          port;
    logic          rd, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            k;
    logic [DW-1:0] rdata;
    logic [DW-1:0] exp_dout;
  } vec_t;
  typedef struct { logic port; logic [DW-1:0] dout; } cpl_t;
  typedef struct { logic wr; logic [AW-1:0] addr; logic [DW-1:0] din; } gnt_t;

  cpl_t cq[$];
  gnt_t gq[$];
  gnt_t cur_g;
  vec_t vecs[7];
  logic [DW-1:0] cmem [0:1023];
  int   checks = 0, errors = 0;
  int   cyc = 0, stall_k = 0, scnt = 0;
  logic prev_req = 1'b0;
  logic last_done_port;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_port(input logic port, input logic rd, input logic wr,
                          input logic [AW-1:0] addr, input logic [DW-1:0] d);
    if (!port) begin
      bus.ReadA = rd; bus.WriteA = wr; bus.AddressA = addr; bus.DataInA = d;
    end else begin
      bus.ReadB = rd; bus.WriteB = wr; bus.AddressB = addr; bus.DataInB = d;
    end
  endtask

  // One cycle: sample at negedge, check against scoreboards, then drive the cache model
  task automatic tick();
    logic req;
    cpl_t c;
    @(negedge CLK);
    cyc++;
    req = bus.MemReadCpu | bus.MemWriteCpu;
    chk("rd_wr_excl", 64'(bus.MemReadCpu & bus.MemWriteCpu), 64'd0);
    chk("done_excl", 64'(bus.DoneA & bus.DoneB), 64'd0);
    if (req && !prev_req) begin
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: got addr %0h expected no grant (cycle %0d)", bus.Address, cyc);
        cur_g = '{bus.MemWriteCpu, bus.Address, bus.DataIn};
      end else begin
        cur_g = gq.pop_front();
      end
    end
    if (req) begin
      chk("grant_op", 64'({bus.MemWriteCpu, bus.MemReadCpu}), cur_g.wr ? 64'd2 : 64'd1);
      chk("grant_addr", 64'(bus.Address), 64'(cur_g.addr));
      chk("grant_din", 64'(bus.DataIn), 64'(cur_g.din));
    end
    if (bus.DoneA || bus.DoneB) begin
      checks++;
      if (cq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got DoneA=%0b DoneB=%0b expected none (cycle %0d)", bus.DoneA, bus.DoneB, cyc);
      end else begin
        c = cq.pop_front();
        chk("done_port", 64'(bus.DoneB), 64'(c.port));
        chk("dout", 64'(c.port ? bus.DataOutB : bus.DataOutA), 64'(c.dout));
      end
      last_done_port = bus.DoneB;
    end
    prev_req = req;
    if (req) begin
      bus.Stall   = (scnt < stall_k);
      bus.DataOut = cmem[bus.Address];
      scnt++;
    end else begin
      scnt        = 0;
      bus.Stall   = 1'b1;          // garbage outside grant: must be ignored
      bus.DataOut = 32'hBAD0BAD0;
    end
  endtask

  task automatic do_vec(input vec_t v);
    int lat, gcyc, lows, low_at;
    logic seen;
    @(posedge CLK); #1;
    if (v.rd && !v.wr) cmem[v.addr] = v.rdata;
    stall_k = v.k;
    set_port(v.port, v.rd, v.wr, v.addr, v.wdata);
    gq.push_back('{v.wr, v.addr, v.wdata});
    cq.push_back('{v.port, v.exp_dout});
    lat = 0; gcyc = 0; lows = 0; low_at = -1; seen = 1'b0;
    while (!seen && lat < 50) begin
      tick();
      if (bus.MemReadCpu | bus.MemWriteCpu) gcyc++;
      seen = v.port ? bus.DoneB : bus.DoneA;
      if (!(v.port ? bus.StallB : bus.StallA)) begin
        lows++;
        if (low_at < 0) low_at = lat;
      end
      if (!seen) lat++;
    end
    chk("latency", 64'(lat), 64'(2 + v.k));
    chk("grant_cycles", 64'(gcyc), 64'(v.k + 1));
    chk("stall_low_at", 64'(low_at), 64'(2 + v.k));
    chk("stall_low_cnt", 64'(lows), 64'd1);
    @(posedge CLK); #1;
    set_port(v.port, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int n_done, last_cyc, budget;
    logic [DW-1:0] alt_a, alt_b;
    for (int i = 0; i < 1024; i++) cmem[i] = 32'h10000000 + i;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    bus.Stall = 1'b1;
    bus.DataOut = '0;

    //                port  rd    wr    addr     wdata          k  rdata          exp_dout
    vecs[0] = '{1'b0, 1'b1, 1'b0, 10'h005, 32'h00000000, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 10'h3F0, 32'h12345678, 5, 32'h00000000, 32'h00000000};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 10'h010, 32'hA5A50001, 0, 32'h00000000, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 10'h3FF, 32'h00000000, 2, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 10'h000, 32'h00000000, 3, 32'h0BADF00D, 32'h0BADF00D};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 10'h001, 32'h00000000, 0, 32'h55AA55AA, 32'h55AA55AA};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 10'h200, 32'hFFFF0000, 1, 32'h00000000, 32'h0BADF00D};

    // reset state
    RST = 1'b1;
    #1 RST = 1'b0;
    #2;
    chk("rst_memread", 64'(bus.MemReadCpu), 64'd0);
    chk("rst_memwrite", 64'(bus.MemWriteCpu), 64'd0);
    chk("rst_done", 64'({bus.DoneA, bus.DoneB}), 64'd0);
    chk("rst_addr", 64'(bus.Address), 64'd0);
    chk("rst_datain", 64'(bus.DataIn), 64'd0);
    chk("rst_douta", 64'(bus.DataOutA), 64'd0);
    chk("rst_doutb", 64'(bus.DataOutB), 64'd0);
    chk("rst_stalla", 64'(bus.StallA), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;

    for (int i = 0; i < 7; i++) do_vec(vecs[i]);

    // both ports reading continuously from reset: strict A,B alternation
    @(posedge CLK); #1;
    RST = 1'b0;
    stall_k = 0;
    alt_a = 32'h0A0A0020;
    alt_b = 32'h0B0B0021;
    cmem[10'h020] = alt_a;
    cmem[10'h021] = alt_b;
    set_port(1'b0, 1'b1, 1'b0, 10'h020, '0);
    set_port(1'b1, 1'b1, 1'b0, 10'h021, '0);
    for (int i = 0; i < 3; i++) begin
      gq.push_back('{1'b0, 10'h020, '0}); cq.push_back('{1'b0, alt_a});
      gq.push_back('{1'b0, 10'h021, '0}); cq.push_back('{1'b1, alt_b});
    end
    @(posedge CLK); #1 RST = 1'b1;
    n_done = 0; last_cyc = 0; budget = 0;
    while (n_done < 6 && budget < 40) begin
      tick();
      budget++;
      if (bus.DoneA || bus.DoneB) begin
        if (n_done > 0) chk("alt_spacing", 64'(cyc - last_cyc), 64'd2);
        last_cyc = cyc;
        n_done++;
      end
    end
    chk("alt_done_count", 64'(n_done), 64'd6);
    // withdraw both while DONE_B is showing so no further grant follows
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) tick();

    // port A withdraws its read one cycle after grant while the cache stalls
    @(posedge CLK); #1;
    stall_k = 4;
    set_port(1'b0, 1'b1, 1'b0, 10'h030, '0);
    gq.push_back('{1'b0, 10'h030, '0});
    cq.push_back('{1'b0, cmem[10'h030]});
    tick();
    tick();
    chk("drop_granted", 64'(bus.MemReadCpu), 64'd1);
    @(posedge CLK); #1;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.DoneA) n_done++;
    end
    chk("drop_done_count", 64'(n_done), 64'd1);

    // reset asserted mid-GRANT_B with the cache stalling
    @(posedge CLK); #1;
    stall_k = 20;
    set_port(1'b1, 1'b0, 1'b1, 10'h100, 32'h00000077);
    gq.push_back('{1'b1, 10'h100, 32'h00000077});
    cq.push_back('{1'b1, 32'h0});
    repeat (4) tick();
    chk("pre_rst_write", 64'(bus.MemWriteCpu), 64'd1);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_memwrite", 64'(bus.MemWriteCpu), 64'd0);
    chk("async_rst_memread", 64'(bus.MemReadCpu), 64'd0);
    chk("async_rst_doneb", 64'(bus.DoneB), 64'd0);
    gq.delete();
    cq.delete();
    stall_k = 0;
    cmem[10'h040] = 32'h4040AAAA;
    set_port(1'b1, 1'b1, 1'b0, 10'h041, '0);
    set_port(1'b0, 1'b1, 1'b0, 10'h040, '0);
    gq.push_back('{1'b0, 10'h040, '0});
    cq.push_back('{1'b0, 32'h4040AAAA});
    #3 RST = 1'b1;
    budget = 0;
    last_done_port = 1'b1;
    while (!(bus.DoneA || bus.DoneB) && budget < 10) begin
      tick();
      budget++;
    end
    chk("post_rst_first_done_a", 64'(bus.DoneA), 64'd1);
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) tick();

    chk("scoreboard_empty", 64'(cq.size() + gq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
